// File: rtl/randomizer_scheduler.sv
// Shares one multi-channel LFSR randomizer between NR_CHANNELS requesters.
// It seeds every channel on command, then grants requests round-robin, one per cycle.
module randomizer_scheduler #(
  parameter  int NR_CHANNELS   = 4,
  parameter  int OUTPUT_WIDTH  = 32,
  localparam int CHANNEL_WIDTH = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     seed_start,
  input  logic [OUTPUT_WIDTH-1:0]  seed_base,
  input  logic [NR_CHANNELS-1:0]   req,
  output logic [NR_CHANNELS-1:0]   gnt,
  output logic                     run,
  output logic                     busy,
  output logic                     out_valid,
  output logic [CHANNEL_WIDTH-1:0] out_ch,
  output logic [OUTPUT_WIDTH-1:0]  out_data,
  output logic [CHANNEL_WIDTH-1:0] rndm_ch,
  output logic                     rndm_ready,
  output logic [OUTPUT_WIDTH-1:0]  rndm_seed,
  output logic                     rndm_rst_n,
  input  logic [OUTPUT_WIDTH-1:0]  rndm_out
);

  typedef enum logic [1:0] {IDLE, SEED, RUN} state_t;

  state_t                   state;
  logic [CHANNEL_WIDTH-1:0] cnt;
  logic [CHANNEL_WIDTH-1:0] ptr;
  logic [CHANNEL_WIDTH-1:0] win;
  logic                     found;
  logic [OUTPUT_WIDTH-1:0]  seed_sum;

  // Round-robin search: channel ptr+1 has highest priority, ptr itself lowest.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    int idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= NR_CHANNELS; i++) begin
      idx = (int'(ptr) + i) % NR_CHANNELS;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = CHANNEL_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    gnt        = '0;
    rndm_ready = 1'b0;
    rndm_ch    = '0;
    rndm_seed  = '0;
    rndm_rst_n = 1'b1;
    seed_sum   = seed_base + OUTPUT_WIDTH'(cnt);
    unique case (state)
      SEED: begin
        rndm_rst_n = 1'b0;
        rndm_ch    = cnt;
        // All-ones is the lock-up state of the XNOR LFSR, so it is never loaded.
        rndm_seed  = (&seed_sum) ? '0 : seed_sum;
      end
      RUN: begin
        if (found) begin
          gnt[win]   = 1'b1;
          rndm_ready = 1'b1;
          rndm_ch    = win;
        end
      end
      default: ;
    endcase
  end

  assign run      = (state == RUN);
  assign busy     = (state == SEED);
  assign out_data = rndm_out;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= CHANNEL_WIDTH'(NR_CHANNELS - 1);
      out_valid <= 1'b0;
      out_ch    <= '0;
    end else begin
      out_valid <= rndm_ready;
      out_ch    <= rndm_ch;
      unique case (state)
        IDLE: begin
          if (seed_start) begin
            state <= SEED;
            cnt   <= '0;
          end
        end
        SEED: begin
          if (cnt == CHANNEL_WIDTH'(NR_CHANNELS - 1)) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (found) ptr <= win;
          // A grant issued in this cycle still completes; only arbitration stops.
          if (seed_start) begin
            state <= SEED;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_randomizer_scheduler.sv
// Directed bench for randomizer_scheduler (4 channels, 8-bit words) with a
// behavioural XNOR Galois LFSR standing in for the shared randomizer.
module tb_randomizer_scheduler;

  localparam int NC = 4;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          seed_start = 1'b0;
  logic [OW-1:0] seed_base = '0;
  logic [NC-1:0] req = '0;
  logic [NC-1:0] gnt;
  logic          run, busy, out_valid;
  logic [1:0]    out_ch, rndm_ch;
  logic [OW-1:0] out_data, rndm_seed;
  logic          rndm_ready, rndm_rst_n;
  logic [OW-1:0] rndm_out = '0;

  int n_checks = 0;
  int n_fail   = 0;

  randomizer_scheduler #(.NR_CHANNELS(NC), .OUTPUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .seed_start(seed_start), .seed_base(seed_base),
    .req(req), .gnt(gnt), .run(run), .busy(busy), .out_valid(out_valid),
    .out_ch(out_ch), .out_data(out_data), .rndm_ch(rndm_ch),
    .rndm_ready(rndm_ready), .rndm_seed(rndm_seed), .rndm_rst_n(rndm_rst_n),
    .rndm_out(rndm_out)
  );

  always #5 clk = ~clk;

  // XNOR Galois LFSR, taps x^8+x^6+x^5+x^4+1; all-ones is its fixed point.
  function automatic logic [OW-1:0] lfsr_step(input logic [OW-1:0] s);
    logic [OW-1:0] x;
    x = ~s;
    x = x[0] ? ((x >> 1) ^ 8'hB8) : (x >> 1);
    return ~x;
  endfunction

  logic [OW-1:0] rnd_state [NC];
  always @(posedge clk) begin
    if (!rndm_rst_n) rnd_state[rndm_ch] <= rndm_seed;
    else if (rndm_ready) begin
      rnd_state[rndm_ch] <= lfsr_step(rnd_state[rndm_ch]);
      rndm_out           <= lfsr_step(rnd_state[rndm_ch]);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          ss;
    logic [OW-1:0] base;
    logic [NC-1:0] req;
    logic          busy, run;
    logic [NC-1:0] gnt;
    logic          rst_n, ready;
    logic [1:0]    ch;
    logic [OW-1:0] seed;
    logic          ov;
    logic [1:0]    och;
  } vec_t;

  vec_t          vecs[$];
  logic [OW-1:0] exp_state [NC];

  task automatic add(input logic ss, input logic [7:0] base, input logic [3:0] rq,
                     input logic bsy, input logic rn, input logic [3:0] g,
                     input logic rsn, input logic rdy, input logic [1:0] ch,
                     input logic [7:0] sd, input logic ov, input logic [1:0] och);
    vec_t v;
    v.ss = ss; v.base = base; v.req = rq; v.busy = bsy; v.run = rn; v.gnt = g;
    v.rst_n = rsn; v.ready = rdy; v.ch = ch; v.seed = sd; v.ov = ov; v.och = och;
    vecs.push_back(v);
  endtask

  task automatic check_data(input string name, input logic [1:0] ch);
    exp_state[ch] = lfsr_step(exp_state[ch]);
    check(name, 32'(out_data), 32'(exp_state[ch]));
  endtask

  initial begin
    //   ss base   req     busy run gnt     rsn rdy ch  seed   ov och
    add(1, 8'h10, 4'hF,   0, 0, 4'b0000, 1, 0, 0, 8'h00, 0, 0); // IDLE, req ignored
    add(0, 8'h10, 4'hF,   1, 0, 4'b0000, 0, 0, 0, 8'h10, 0, 0);
    add(0, 8'h10, 4'hF,   1, 0, 4'b0000, 0, 0, 1, 8'h11, 0, 0);
    add(0, 8'h10, 4'hF,   1, 0, 4'b0000, 0, 0, 2, 8'h12, 0, 1);
    add(0, 8'h10, 4'hF,   1, 0, 4'b0000, 0, 0, 3, 8'h13, 0, 2);
    add(0, 8'h10, 4'hF,   0, 1, 4'b0001, 1, 1, 0, 8'h00, 0, 3); // round robin
    add(0, 8'h10, 4'hF,   0, 1, 4'b0010, 1, 1, 1, 8'h00, 1, 0);
    add(0, 8'h10, 4'hF,   0, 1, 4'b0100, 1, 1, 2, 8'h00, 1, 1);
    add(0, 8'h10, 4'hF,   0, 1, 4'b1000, 1, 1, 3, 8'h00, 1, 2);
    add(0, 8'h10, 4'hF,   0, 1, 4'b0001, 1, 1, 0, 8'h00, 1, 3);
    add(0, 8'h10, 4'hF,   0, 1, 4'b0010, 1, 1, 1, 8'h00, 1, 0);
    add(0, 8'h10, 4'hF,   0, 1, 4'b0100, 1, 1, 2, 8'h00, 1, 1);
    add(0, 8'h10, 4'hF,   0, 1, 4'b1000, 1, 1, 3, 8'h00, 1, 2);
    add(0, 8'h10, 4'h4,   0, 1, 4'b0100, 1, 1, 2, 8'h00, 1, 3); // single requester
    add(0, 8'h10, 4'h4,   0, 1, 4'b0100, 1, 1, 2, 8'h00, 1, 2);
    add(0, 8'h10, 4'h4,   0, 1, 4'b0100, 1, 1, 2, 8'h00, 1, 2);
    add(0, 8'h10, 4'h9,   0, 1, 4'b1000, 1, 1, 3, 8'h00, 1, 2); // sparse, ptr=2
    add(0, 8'h10, 4'h9,   0, 1, 4'b0001, 1, 1, 0, 8'h00, 1, 3);
    add(0, 8'h10, 4'h9,   0, 1, 4'b1000, 1, 1, 3, 8'h00, 1, 0);
    add(0, 8'h10, 4'h0,   0, 1, 4'b0000, 1, 0, 0, 8'h00, 1, 3);
    add(0, 8'h10, 4'h0,   0, 1, 4'b0000, 1, 0, 0, 8'h00, 0, 0);
    add(1, 8'hFD, 4'h0,   0, 1, 4'b0000, 1, 0, 0, 8'h00, 0, 0); // re-seed, wrap + guard
    add(0, 8'hFD, 4'h0,   1, 0, 4'b0000, 0, 0, 0, 8'hFD, 0, 0);
    add(0, 8'hFD, 4'h0,   1, 0, 4'b0000, 0, 0, 1, 8'hFE, 0, 0);
    add(0, 8'hFD, 4'h0,   1, 0, 4'b0000, 0, 0, 2, 8'h00, 0, 1);
    add(0, 8'hFD, 4'h0,   1, 0, 4'b0000, 0, 0, 3, 8'h00, 0, 2);
    add(0, 8'hFD, 4'h0,   0, 1, 4'b0000, 1, 0, 0, 8'h00, 0, 3);
    add(0, 8'hFD, 4'h4,   0, 1, 4'b0100, 1, 1, 2, 8'h00, 0, 0);
    add(0, 8'hFD, 4'h0,   0, 1, 4'b0000, 1, 0, 0, 8'h00, 1, 2);

    repeat (2) @(posedge clk);
    #1;
    check("reset.run", 32'(run), 0);
    check("reset.busy", 32'(busy), 0);
    check("reset.gnt", 32'(gnt), 0);
    check("reset.rndm_rst_n", 32'(rndm_rst_n), 1);
    check("reset.out_valid", 32'(out_valid), 0);
    check("reset.out_ch", 32'(out_ch), 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      seed_start = vecs[i].ss;
      seed_base  = vecs[i].base;
      req        = vecs[i].req;
      #1;
      check($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("v%0d.run", i), 32'(run), 32'(vecs[i].run));
      check($sformatf("v%0d.gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      check($sformatf("v%0d.rndm_rst_n", i), 32'(rndm_rst_n), 32'(vecs[i].rst_n));
      check($sformatf("v%0d.rndm_ready", i), 32'(rndm_ready), 32'(vecs[i].ready));
      check($sformatf("v%0d.rndm_ch", i), 32'(rndm_ch), 32'(vecs[i].ch));
      if (!vecs[i].rst_n) begin
        check($sformatf("v%0d.rndm_seed", i), 32'(rndm_seed), 32'(vecs[i].seed));
        exp_state[vecs[i].ch] = vecs[i].seed;
      end
      check($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      check($sformatf("v%0d.out_ch", i), 32'(out_ch), 32'(vecs[i].och));
      if (vecs[i].ov) check_data($sformatf("v%0d.out_data", i), vecs[i].och);
      @(posedge clk);
      #1;
    end

    // Re-seed in the same cycle as a grant to ch1 (ptr=2, only ch1 requesting).
    seed_start = 1'b1;
    req        = 4'b0010;
    #1;
    check("reseed.gnt", 32'(gnt), 32'b0010);
    tick();
    seed_start = 1'b0;
    req        = 4'b1111;
    #1;
    check("reseed.out_valid", 32'(out_valid), 1);
    check("reseed.out_ch", 32'(out_ch), 1);
    check_data("reseed.out_data", 2'd1);
    for (int k = 0; k < NC; k++) begin
      check($sformatf("reseed.busy%0d", k), 32'(busy), 1);
      check($sformatf("reseed.gnt%0d", k), 32'(gnt), 0);
      check($sformatf("reseed.ready%0d", k), 32'(rndm_ready), 0);
      tick();
    end
    check("reseed.done_busy", 32'(busy), 0);
    check("reseed.gnt_after", 32'(gnt), 32'b0100);

    // Reset in the cycle after a grant: the in-flight word is dropped.
    tick();
    check("midrst.pre_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("midrst.out_valid", 32'(out_valid), 0);
    check("midrst.run", 32'(run), 0);
    check("midrst.gnt", 32'(gnt), 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("midrst.idle_gnt%0d", k), 32'(gnt), 0);
      check($sformatf("midrst.idle_run%0d", k), 32'(run), 0);
      check($sformatf("midrst.idle_busy%0d", k), 32'(busy), 0);
      tick();
    end
    seed_start = 1'b1;
    tick();
    seed_start = 1'b0;
    #1;
    check("midrst.seed_busy", 32'(busy), 1);
    check("midrst.seed_ch", 32'(rndm_ch), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
